// File: rtl/sort_writeback.sv
// Writes sorted 16-tuple blocks back to a mem bank as even/odd row pairs, one row per cycle.
// Two-deep block buffer with bypass so row 0 of a block lands the cycle after it is accepted.
package sort_writeback_pkg;
  typedef struct packed {
    logic [15:0] key;
    logic [15:0] val;
  } tuple_pair_t;

  localparam int TUPLE_WIDTH       = $bits(tuple_pair_t);
  localparam int ARR_16_FLAT_WIDTH = 16 * TUPLE_WIDTH;

  function automatic tuple_pair_t index_flat(input logic [ARR_16_FLAT_WIDTH-1:0] flat,
                                             input logic [3:0] idx);
    return flat[int'(idx)*TUPLE_WIDTH +: TUPLE_WIDTH];
  endfunction
endpackage

module sort_writeback
  import sort_writeback_pkg::*;
#(
  parameter int                         BANK_ADDR_WIDTH = 6,
  parameter logic [BANK_ADDR_WIDTH-1:0] BASE_ADDR       = '0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start_in,
  input  logic [31:0]                  stream_len_in,
  input  logic                         valid_in,
  input  logic [ARR_16_FLAT_WIDTH-1:0] pairs_in_flat,
  output logic                         ready_out,
  output logic                         write_en_out,
  output logic [BANK_ADDR_WIDTH-1:0]   row_addr_out,
  output tuple_pair_t                  even_data_out,
  output tuple_pair_t                  odd_data_out,
  output logic                         done_out,
  output logic                         overflow_out,
  output logic                         addr_err_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [BANK_ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                       state_q, state_d;
  logic [ARR_16_FLAT_WIDTH-1:0] buf_q [2];
  logic [ARR_16_FLAT_WIDTH-1:0] buf_d [2];
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [1:0]                   count_q, count_d;
  logic [2:0]                   row_q, row_d;
  logic [31:0]                  remaining_q, remaining_d;
  logic [BANK_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                         addr_full_q, addr_full_d;
  logic                         ready_q, ready_d;
  logic                         write_en_q, write_en_d;
  logic [BANK_ADDR_WIDTH-1:0]   row_addr_q, row_addr_d;
  tuple_pair_t                  even_q, even_d;
  tuple_pair_t                  odd_q, odd_d;
  logic                         done_q, done_d;
  logic                         overflow_q, overflow_d;
  logic                         addr_err_q, addr_err_d;

  logic                         have_blk, accept, pop;
  logic [ARR_16_FLAT_WIDTH-1:0] head;
  logic [31:0]                  rem_next;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    row_d       = row_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    addr_full_d = addr_full_q;
    write_en_d  = 1'b0;
    row_addr_d  = row_addr_q;
    even_d      = even_q;
    odd_d       = odd_q;
    overflow_d  = overflow_q;
    addr_err_d  = addr_err_q;
    have_blk    = 1'b0;
    accept      = 1'b0;
    pop         = 1'b0;
    rem_next    = remaining_q;
    // An empty buffer bypasses the incoming block straight to the row writer.
    head        = (count_q == 2'd0) ? pairs_in_flat : buf_q[rd_ptr_q];

    case (state_q)
      IDLE: begin
        if (start_in) begin
          remaining_d = stream_len_in;
          addr_d      = BASE_ADDR;
          addr_full_d = 1'b0;
          state_d     = (stream_len_in == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        have_blk = (count_q != 2'd0) || valid_in;
        if (have_blk) begin
          pop         = (row_q == 3'd7);
          even_d      = index_flat(head, {row_q, 1'b0});
          odd_d       = (remaining_q == 32'd1) ? '1 : index_flat(head, {row_q, 1'b1});
          rem_next    = (remaining_q >= 32'd2) ? remaining_q - 32'd2 : 32'd0;
          remaining_d = rem_next;
          row_d       = row_q + 3'd1;
          if (addr_full_q) begin
            addr_err_d = 1'b1;
          end else begin
            write_en_d = 1'b1;
            row_addr_d = addr_q;
            if (addr_q == LAST_ADDR) addr_full_d = 1'b1;
            else                     addr_d      = addr_q + 1'b1;
          end
        end
        // A full buffer still takes a block in the cycle its head retires.
        accept = valid_in && ((count_q != 2'd2) || pop);
        if (valid_in && !accept) overflow_d = 1'b1;
        if (accept) begin
          buf_d[wr_ptr_q] = pairs_in_flat;
          wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, accept} - {1'b0, pop};
        if (have_blk && rem_next == 32'd0) begin
          state_d = DONE;
          count_d = 2'd0;
          row_d   = 3'd0;
        end
      end
      DONE: begin
        if (valid_in) overflow_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == RUN) && (count_d != 2'd2);
    done_d  = done_q || (state_q == DONE) ||
              (state_q == IDLE && start_in && stream_len_in == 32'd0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      row_q       <= 3'd0;
      remaining_q <= 32'd0;
      addr_q      <= '0;
      addr_full_q <= 1'b0;
      ready_q     <= 1'b0;
      write_en_q  <= 1'b0;
      row_addr_q  <= '0;
      even_q      <= '0;
      odd_q       <= '0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      row_q       <= row_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      addr_full_q <= addr_full_d;
      ready_q     <= ready_d;
      write_en_q  <= write_en_d;
      row_addr_q  <= row_addr_d;
      even_q      <= even_d;
      odd_q       <= odd_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      addr_err_q  <= addr_err_d;
    end
    buf_q <= buf_d;
  end

  assign ready_out     = ready_q;
  assign write_en_out  = write_en_q;
  assign row_addr_out  = row_addr_q;
  assign even_data_out = even_q;
  assign odd_data_out  = odd_q;
  assign done_out      = done_q;
  assign overflow_out  = overflow_q;
  assign addr_err_out  = addr_err_q;

endmodule

// File: tb/tb_sort_writeback.sv
// Bench for sort_writeback: per-run stimulus tables checked against a block/row schedule model.
module tb_sort_writeback;
  import sort_writeback_pkg::*;

  localparam int AW   = 6;
  localparam int NROW = 1 << AW;
  localparam int MAXC = 2048;
  localparam int MAXB = 32;
  localparam int TW   = $bits(tuple_pair_t);
  localparam int AFW  = ARR_16_FLAT_WIDTH;
  localparam int INF  = 1 << 30;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start_in = 1'b0;
  logic [31:0]      stream_len_in = '0;
  logic             valid_in = 1'b0;
  logic [AFW-1:0]   pairs_in_flat = '0;
  logic             ready_out, write_en_out, done_out, overflow_out, addr_err_out;
  logic [AW-1:0]    row_addr_out;
  tuple_pair_t      even_data_out, odd_data_out;

  sort_writeback #(.BANK_ADDR_WIDTH(AW), .BASE_ADDR('0)) dut (
    .clock(clock), .reset(reset), .start_in(start_in), .stream_len_in(stream_len_in),
    .valid_in(valid_in), .pairs_in_flat(pairs_in_flat), .ready_out(ready_out),
    .write_en_out(write_en_out), .row_addr_out(row_addr_out),
    .even_data_out(even_data_out), .odd_data_out(odd_data_out),
    .done_out(done_out), .overflow_out(overflow_out), .addr_err_out(addr_err_out)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Stimulus table for one run; start_in is always presented at cycle 0.
  int             nblk;
  int             blk_cyc [MAXB];
  logic [AFW-1:0] blk_dat [MAXB];

  // Expected outputs, indexed by the cycle in which they are visible.
  bit             exp_we   [MAXC];
  logic [AW-1:0]  exp_addr [MAXC];
  tuple_pair_t    exp_even [MAXC];
  tuple_pair_t    exp_odd  [MAXC];
  int             done_vis, ovf_vis, err_vis, last_wr, nacc;
  int             acc_a [MAXB];
  int             acc_s [MAXB];

  function automatic tuple_pair_t tup(input int b, input int t);
    logic [AFW-1:0] d;
    d = blk_dat[b];
    return d[t*TW +: TW];
  endfunction

  task automatic set_blk(input int i, input int cyc, input bit rnd);
    logic [AFW-1:0] d;
    logic [31:0]    v;
    for (int t = 0; t < 16; t++) begin
      v = rnd ? $urandom : 32'(i * 16 + t);
      d[t*TW +: TW] = v[TW-1:0];
    end
    blk_cyc[i] = cyc;
    blk_dat[i] = d;
  endtask

  // Blocks are written in acceptance order, each taking 8 consecutive cycles and starting
  // no earlier than its own arrival; a block holds a buffer slot until its row 7 is written.
  task automatic build_model(input int len);
    int r, written, prev_s, a, s, held, w;
    for (int c = 0; c < MAXC; c++) begin
      exp_we[c] = 1'b0; exp_addr[c] = '0; exp_even[c] = '0; exp_odd[c] = '0;
    end
    done_vis = INF; ovf_vis = INF; err_vis = INF;
    r = (len + 1) / 2; written = 0; prev_s = -100; nacc = 0; last_wr = -1;
    if (len == 0) begin
      done_vis = 1; last_wr = 0;
    end
    for (int i = 0; i < nblk; i++) begin
      a = blk_cyc[i];
      if (last_wr >= 0 && a > last_wr) begin
        if (a + 1 < ovf_vis) ovf_vis = a + 1;
        continue;
      end
      held = 0;
      for (int j = 0; j < nacc; j++) if (acc_s[j] + 7 > a) held++;
      if (held >= 2) begin
        if (a + 1 < ovf_vis) ovf_vis = a + 1;
        continue;
      end
      s = (a > prev_s + 8) ? a : prev_s + 8;
      prev_s = s;
      acc_a[nacc] = a; acc_s[nacc] = s; nacc++;
      for (int k = 0; k < 8; k++) begin
        if (written < r) begin
          w = s + k;
          if (written < NROW) begin
            exp_we[w+1]   = 1'b1;
            exp_addr[w+1] = written[AW-1:0];
            exp_even[w+1] = tup(i, 2*k);
            exp_odd[w+1]  = (written == r - 1 && (len % 2) == 1) ? '1 : tup(i, 2*k + 1);
          end else if (w + 1 < err_vis) begin
            err_vis = w + 1;
          end
          written++;
          if (written == r) begin
            last_wr = w; done_vis = w + 2;
          end
        end
      end
    end
  endtask

  task automatic run_test(input int len, input int rst_at);
    int hz, held;
    bit rdy;
    build_model(len);
    hz = blk_cyc[nblk-1] + 8 * (nblk + 1) + 12;
    for (int c = 0; c <= hz; c++) begin
      @(negedge clock);
      if (rst_at >= 0 && c == rst_at + 1) begin
        check("rst_we",    write_en_out, 0);
        check("rst_ready", ready_out, 0);
        check("rst_done",  done_out, 0);
        check("rst_ovf",   overflow_out, 0);
        check("rst_addr",  row_addr_out, 0);
        check("rst_even",  even_data_out, 0);
        check("rst_odd",   odd_data_out, 0);
        reset = 1'b0; valid_in = 1'b0;
        return;
      end
      if (c == 0) begin
        check("init_addr", row_addr_out, 0);
        check("init_even", even_data_out, 0);
        check("init_odd",  odd_data_out, 0);
      end
      check("write_en", write_en_out, exp_we[c]);
      if (exp_we[c]) begin
        check("row_addr", row_addr_out, exp_addr[c]);
        check("even",     even_data_out, exp_even[c]);
        check("odd",      odd_data_out, exp_odd[c]);
      end
      check("done",     done_out, c >= done_vis);
      check("overflow", overflow_out, c >= ovf_vis);
      check("addr_err", addr_err_out, c >= err_vis);
      held = 0;
      for (int j = 0; j < nacc; j++) if (acc_a[j] < c && acc_s[j] + 7 >= c) held++;
      rdy = (len != 0) && (c >= 1) && (last_wr < 0 || c <= last_wr) && (held < 2);
      check("ready", ready_out, rdy);

      start_in      = (c == 0);
      stream_len_in = 32'(len);
      reset         = (c == rst_at);
      valid_in      = 1'b0;
      for (int i = 0; i < nblk; i++) begin
        if (blk_cyc[i] == c) begin
          valid_in      = 1'b1;
          pairs_in_flat = blk_dat[i];
        end
      end
    end
    start_in = 1'b0; valid_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; start_in = 1'b0; valid_in = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int cyc, len;
    do_reset();
    nblk = 1; set_blk(0, 1, 0);
    run_test(16, -1);

    do_reset();
    nblk = 2; set_blk(0, 1, 1); set_blk(1, 2, 1);
    run_test(32, -1);

    do_reset();
    nblk = 2; set_blk(0, 1, 0); set_blk(1, 2, 1);
    run_test(19, -1);

    do_reset();
    nblk = 3; set_blk(0, 1, 1); set_blk(1, 2, 1); set_blk(2, 3, 1);
    run_test(64, -1);

    do_reset();
    nblk = 1; set_blk(0, 1, 1);
    run_test(16, 6);
    nblk = 1; set_blk(0, 1, 0);
    run_test(16, -1);

    do_reset();
    nblk = 1; set_blk(0, 3, 1);
    run_test(0, -1);

    do_reset();
    nblk = 9;
    for (int i = 0; i < 9; i++) set_blk(i, 1 + 8 * i, 1);
    run_test(140, -1);

    do_reset();
    nblk = 3; set_blk(0, 1, 1); set_blk(1, 2, 1); set_blk(2, 8, 1);
    run_test(48, -1);

    for (int t = 0; t < 10; t++) begin
      do_reset();
      len  = int'($urandom_range(1, 150));
      nblk = (len + 15) / 16 + int'($urandom_range(0, 3));
      if (nblk > 14) nblk = 14;
      cyc  = int'($urandom_range(1, 3));
      for (int i = 0; i < nblk; i++) begin
        set_blk(i, cyc, 1);
        cyc += int'($urandom_range(1, 12));
      end
      run_test(len, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
